// File: rtl/mrd_pkg.sv
// Shared definitions for the block-floating-point margin monitor.
// Holds the default sample width, the largest reportable margin, the
// frame-tracking FSM state type and a small 2-bit minimum helper.
package mrd_pkg;

   localparam int unsigned DW_DEFAULT = 18;
   localparam logic [1:0]  MAX_MARGIN = 2'd3;

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   function automatic logic [1:0] min2(input logic [1:0] a, input logic [1:0] b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/mrd_sign_margin.sv
// Headroom of one signed sample: the number of bits directly below the
// sign bit that repeat it, looking at most three bits down.
// Ports:
//   x  in  DW signed  sample
//   m  out 2          margin, 0..3
module mrd_sign_margin
   import mrd_pkg::*;
#(
   parameter int unsigned DW = DW_DEFAULT
) (
   input  logic signed [DW-1:0] x,
   output logic        [1:0]    m
);

   // Only the top four bits decide the margin.
   logic unused_low;
   assign unused_low = ^x[DW-5:0];

   always_comb begin
      m = 2'd0;
      if (x[DW-2] == x[DW-1]) begin
         m = 2'd1;
         if (x[DW-3] == x[DW-1]) begin
            m = 2'd2;
            if (x[DW-4] == x[DW-1]) begin
               m = MAX_MARGIN;
            end
         end
      end
   end

endmodule

// File: rtl/mrd_bfp_margin.sv
// Frame margin monitor for a radix-5 butterfly output stream.
// Data passes through with one cycle of latency. For every frame, the
// smallest per-sample headroom over all beats is reported two cycles after
// the last beat, together with the block exponent seen on that beat.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_val, sop_in        beat valid, first beat of frame
//   din_real/din_imag     5 complex butterfly outputs
//   exp_in                running block exponent
//   frm_len               beats per frame, sampled at sop
//   out_val, dout_*       one-cycle delayed passthrough
//   margin_out, exp_out   frame result, held between pulses
//   margin_val            one-cycle result strobe
//   frm_err               one-cycle protocol error strobe
module mrd_bfp_margin
   import mrd_pkg::*;
#(
   parameter int unsigned DW = DW_DEFAULT,
   parameter int unsigned LW = 12
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_val,
   input  logic                 sop_in,
   input  logic signed [DW-1:0] din_real [0:4],
   input  logic signed [DW-1:0] din_imag [0:4],
   input  logic        [3:0]    exp_in,
   input  logic        [LW-1:0] frm_len,
   output logic                 out_val,
   output logic signed [DW-1:0] dout_real [0:4],
   output logic signed [DW-1:0] dout_imag [0:4],
   output logic        [1:0]    margin_out,
   output logic        [3:0]    exp_out,
   output logic                 margin_val,
   output logic                 frm_err
);

   logic [1:0] m_re [0:4];
   logic [1:0] m_im [0:4];
   logic [1:0] beat_m;

   state_t        state;
   logic [LW-1:0] cnt;
   logic [LW-1:0] cnt_inc;
   logic [LW-1:0] len_q;

   // Stage 1: beat margin plus frame-position flags of that beat.
   logic       s1_val;
   logic       s1_first;
   logic       s1_last;
   logic [1:0] s1_margin;
   logic [3:0] s1_exp;

   // Stage 2: running frame minimum.
   logic [1:0] frame_min;
   logic [1:0] frame_min_new;

   for (genvar g = 0; g < 5; g++) begin : g_margin
      mrd_sign_margin #(.DW(DW)) u_re (
         .x (din_real[g]),
         .m (m_re[g])
      );
      mrd_sign_margin #(.DW(DW)) u_im (
         .x (din_imag[g]),
         .m (m_im[g])
      );
   end

   always_comb begin
      beat_m = MAX_MARGIN;
      for (int i = 0; i < 5; i++) begin
         beat_m = min2(beat_m, m_re[i]);
         beat_m = min2(beat_m, m_im[i]);
      end
   end

   assign cnt_inc = cnt + LW'(1);

   // Passthrough.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_val <= 1'b0;
         for (int i = 0; i < 5; i++) begin
            dout_real[i] <= '0;
            dout_imag[i] <= '0;
         end
      end else begin
         out_val <= in_val;
         for (int i = 0; i < 5; i++) begin
            dout_real[i] <= din_real[i];
            dout_imag[i] <= din_imag[i];
         end
      end
   end

   // Frame FSM and stage 1. Any sop seen in RUN is premature, because the
   // last beat always drops the FSM back to IDLE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         len_q     <= '0;
         frm_err   <= 1'b0;
         s1_val    <= 1'b0;
         s1_first  <= 1'b0;
         s1_last   <= 1'b0;
         s1_margin <= MAX_MARGIN;
         s1_exp    <= '0;
      end else begin
         frm_err   <= 1'b0;
         s1_val    <= 1'b0;
         s1_first  <= 1'b0;
         s1_last   <= 1'b0;
         s1_margin <= beat_m;
         s1_exp    <= exp_in;
         if (in_val) begin
            if (sop_in) begin
               if (frm_len == '0) begin
                  frm_err <= 1'b1;
                  state   <= IDLE;
               end else begin
                  frm_err  <= (state == RUN);
                  len_q    <= frm_len;
                  cnt      <= LW'(1);
                  s1_val   <= 1'b1;
                  s1_first <= 1'b1;
                  if (frm_len == LW'(1)) begin
                     s1_last <= 1'b1;
                     state   <= IDLE;
                  end else begin
                     state <= RUN;
                  end
               end
            end else if (state == RUN) begin
               cnt    <= cnt_inc;
               s1_val <= 1'b1;
               if (cnt_inc == len_q) begin
                  s1_last <= 1'b1;
                  state   <= IDLE;
               end
            end
         end
      end
   end

   // A first beat restarts the minimum, so a discarded partial frame never
   // leaks into the next result.
   assign frame_min_new = s1_first ? s1_margin : min2(frame_min, s1_margin);

   // Stage 2 and frame result.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         frame_min  <= MAX_MARGIN;
         margin_out <= MAX_MARGIN;
         exp_out    <= '0;
         margin_val <= 1'b0;
      end else begin
         margin_val <= 1'b0;
         if (s1_val) begin
            frame_min <= frame_min_new;
            if (s1_last) begin
               margin_out <= frame_min_new;
               exp_out    <= s1_exp;
               margin_val <= 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/mrd_bfp_margin.md
MRD_BFP_MARGIN -- requirements
Module: mrd_bfp_margin

Interface
REQ-001 Parameter DW, default 18: sample width for din/dout, real and imag.
REQ-002 Parameter LW, default 12: width of frm_len and the beat counter.
REQ-003 Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- in_val  in  1  butterfly output beat valid.
- sop_in  in  1  first beat of a frame; qualified by in_val.
- din_real[0:4]  in  5xDW signed  butterfly outputs, real part.
- din_imag[0:4]  in  5xDW signed  butterfly outputs, imaginary part.
- exp_in  in  4 unsigned  running block exponent from the butterfly.
- frm_len  in  LW unsigned  beats per frame; sampled at sop.
- out_val  out  1  passthrough valid.
- dout_real[0:4]  out  5xDW signed  passthrough data, real part.
- dout_imag[0:4]  out  5xDW signed  passthrough data, imaginary part.
- margin_out  out  2 unsigned  frame margin for the next stage's margin_in.
- exp_out  out  4 unsigned  frame exponent.
- margin_val  out  1  one-cycle pulse; margin_out and exp_out are valid.
- frm_err  out  1  one-cycle pulse on a protocol error.
REQ-004 The block SHALL use one clock, clk; reset rst_n SHALL be synchronous and active-low.

Function
REQ-005 Passthrough: out_val, dout_real and dout_imag SHALL equal in_val, din_real and din_imag delayed by exactly 1 cycle, in every state.
REQ-006 Per-sample margin m(x):
- Count the bits among x[DW-2:DW-4] equal to x[DW-1], counting contiguously from bit DW-2.
- m(x) is that count, capped at 3; so m(0)=3 and m(-1)=3.
REQ-007 Beat margin SHALL be the minimum of m() over all 10 values of the beat, registered in pipeline stage 1.
REQ-008 Frame margin SHALL be the running minimum of beat margins, held in stage 2; it is initialised to 3 at each accepted sop.
REQ-009 FSM states: IDLE and RUN.
- IDLE: an in_val beat without sop_in SHALL be passed through but excluded from margin statistics.
REQ-010 Accepted sop (in_val & sop_in & frm_len!=0), from either state:
- latch frm_len;
- set beat count to 1;
- restart statistics;
- enter RUN.
REQ-011 In RUN, each in_val beat without sop_in SHALL increment the count. in_val low SHALL hold all state (gaps allowed).
REQ-012 Last beat: the beat on which count equals the latched frm_len (including the sop beat when frm_len=1). The FSM SHALL return to IDLE after this beat.
REQ-013 End of frame:
- margin_val SHALL pulse exactly 2 cycles after the last beat;
- margin_out SHALL be the frame minimum, including the last beat;
- exp_out SHALL be exp_in sampled on the last beat.
REQ-014 margin_out and exp_out SHALL hold their values between pulses.
REQ-015 frm_err SHALL pulse 1 cycle after either error:
- sop_in with in_val in RUN before the last beat: the partial frame is discarded, no margin_val is issued, and the new frame starts (REQ-010);
- sop_in with in_val while frm_len==0: the FSM goes to or stays in IDLE.
REQ-016 A sop beat arriving the cycle after a last beat is not an error. The pending margin_val pulse for the finished frame SHALL still be issued, unaffected by the new frame.

Reset
REQ-017 While rst_n=0 at a clk edge, the following SHALL be 0: out_val, all dout, margin_val, frm_err, exp_out, beat count.
REQ-018 While rst_n=0, margin_out SHALL be 3, the FSM SHALL be IDLE, and pipeline stats SHALL be invalidated.
REQ-019 Reset mid-frame SHALL discard the frame; no margin_val or frm_err SHALL follow.

Structure
REQ-020 Package mrd_pkg SHALL hold: DW default, MAX_MARGIN=3, and the FSM state enum (IDLE, RUN).
REQ-021 A single combinational sub-module, mrd_sign_margin, SHALL compute m(x) for one sample; it SHALL be instantiated 10 times.

Verification
REQ-022 Bench SHALL cover the following directed scenarios:
- frm_len=4, 4 contiguous beats with all samples 0x00100 -> margin_val 2 cycles after beat 4, margin_out=3, exp_out=exp_in of beat 4.
- frm_len=3, beat 2 contains one sample 0x1FFFF (max positive) -> margin_out=0; the other beats are irrelevant.
- frm_len=3, beats with minima m=2, 1, 2, and in_val gaps of 2 cycles between beats -> margin_out=1; the pulse follows the third beat by 2 cycles.
- frm_len=5, sop re-asserted on beat 3 -> frm_err pulse, no margin_val; the new frame of 5 completes normally.
- frm_len=1 on back-to-back sop beats -> one margin_val per beat; no frm_err.
- rst_n low for 1 cycle mid-frame -> outputs reset per REQ-017/018, no margin_val; the passthrough latency stays 1 cycle throughout.
